// File: rtl/sub_bytes_serial_pkg.sv
// Shared AES definitions for the byte-serial SubBytes stage: widths, FSM encoding,
// byte addressing helper and the forward S-box table.
package sub_bytes_serial_pkg;

    localparam int AES_BYTES   = 16;
    localparam int AES_STATE_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUB,
        ST_DONE
    } sb_state_e;

    // Byte i of the state lives at [127-8i -: 8] (FIPS-197 ordering, byte 0 is the MSB).
    function automatic logic [6:0] byte_msb(input logic [3:0] idx);
        return 7'd127 - {idx, 3'b000};
    endfunction

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

endpackage

// File: rtl/sub_bytes_serial_if.sv
// Handshake bundle between AddRoundKey (master side) and the SubBytes stage (slave side).
interface sub_bytes_serial_if;
    import sub_bytes_serial_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] state_in;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] state_out;
    logic                   busy;

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );

endinterface

// File: rtl/sub_bytes_serial_sbox.sv
// Purely combinational AES forward S-box lookup.
module sbox
    import sub_bytes_serial_pkg::*;
(
    input  logic [7:0] originalByte,
    output logic [7:0] subbedByte
);

    logic [10:0] tbl_msb;

    assign tbl_msb    = 11'd2047 - {originalByte, 3'b000};
    assign subbedByte = SBOX_TABLE[tbl_msb -: 8];

endmodule

// File: rtl/sub_bytes_serial.sv
// Byte-serial SubBytes: substitutes PAR bytes of the held state per cycle, then
// presents the full result until the downstream stage takes it.
module sub_bytes_serial
    import sub_bytes_serial_pkg::*;
#(
    parameter int PAR = 1
) (
    input  logic                clk,
    input  logic                rst,
    sub_bytes_serial_if.slave   bus
);

    localparam int         NBYTES = AES_BYTES;
    localparam logic [3:0] LAST   = 4'(NBYTES - PAR);
    localparam logic [3:0] STEP   = 4'(PAR);

    if (!(PAR == 1 || PAR == 2 || PAR == 4 || PAR == 8 || PAR == 16)) begin : g_bad_par
        $error("sub_bytes_serial: PAR must be 1, 2, 4, 8 or 16");
    end

    sb_state_e              state, state_next;
    logic [3:0]             cnt, cnt_next;
    logic [AES_STATE_W-1:0] st, st_next;
    logic [7:0]             lane_in  [PAR];
    logic [7:0]             lane_out [PAR];

    // Lane g works on byte cnt+g; cnt is always a multiple of PAR so this never wraps.
    for (genvar g = 0; g < PAR; g++) begin : g_lane
        assign lane_in[g] = st[byte_msb(cnt + 4'(g)) -: 8];

        sbox u_sbox (
            .originalByte (lane_in[g]),
            .subbedByte   (lane_out[g])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; st is cleared on reset so an aborted state never lingers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            st    <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            st    <= st_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        st_next    = st;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    st_next    = bus.state_in;
                    cnt_next   = '0;
                    state_next = ST_SUB;
                end
            end
            ST_SUB: begin
                for (int g = 0; g < PAR; g++) begin
                    st_next[byte_msb(cnt + 4'(g)) -: 8] = lane_out[g];
                end
                cnt_next = cnt + STEP;
                if (cnt == LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Partially substituted bytes stay hidden: state_out is zero outside DONE.
    assign bus.in_ready  = (state == ST_IDLE) && !rst;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.state_out = (state == ST_DONE) ? st : '0;

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Directed bench for sub_bytes_serial: PAR=1 main instance plus PAR=2/4/16 instances
// sharing a common stimulus for the latency/result comparison.
module tb_sub_bytes_serial;
    import sub_bytes_serial_pkg::*;

    localparam logic [127:0] T1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] T1_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] T2_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] T2_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] ZEROS  = 128'h0;
    localparam logic [127:0] ONES   = {16{8'hff}};
    localparam logic [127:0] ALL63  = {16{8'h63}};
    localparam logic [127:0] ALL16  = {16{8'h16}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sub_bytes_serial_if bus1 ();
    sub_bytes_serial_if bus2 ();
    sub_bytes_serial_if bus4 ();
    sub_bytes_serial_if bus16 ();

    sub_bytes_serial #(.PAR(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    sub_bytes_serial #(.PAR(2))  u_dut2  (.clk(clk), .rst(rst), .bus(bus2.slave));
    sub_bytes_serial #(.PAR(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
    sub_bytes_serial #(.PAR(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    logic         p_valid = 1'b0;
    logic [127:0] p_state = '0;

    assign bus2.in_valid   = p_valid;
    assign bus2.state_in   = p_state;
    assign bus2.out_ready  = 1'b1;
    assign bus4.in_valid   = p_valid;
    assign bus4.state_in   = p_state;
    assign bus4.out_ready  = 1'b1;
    assign bus16.in_valid  = p_valid;
    assign bus16.state_in  = p_state;
    assign bus16.out_ready = 1'b1;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference S-box from GF(2^8) inversion and the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] v);
        logic [7:0] r    = 8'h01;
        logic [7:0] base = v;
        logic [7:0] e    = 8'd254;
        logic [7:0] s;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        if (v == 8'h00) r = 8'h00;
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] v);
        logic [127:0] o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = ref_sbox(v[127-8*i -: 8]);
        return o;
    endfunction

    task automatic check1(input string tag, input logic obs, input logic exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkint(input string tag, input int obs, input int exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one state to the PAR=1 instance; returns edges from accept (counted as 1)
    // until out_valid is seen, and the presented state. Caller sits at a negedge in IDLE.
    task automatic run1(input logic [127:0] s, output int lat, output logic [127:0] res);
        check1("idle in_ready", bus1.in_ready, 1'b1);
        bus1.in_valid = 1'b1;
        bus1.state_in = s;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        lat = 1;
        check1("sub busy", bus1.busy, 1'b1);
        check1("sub in_ready", bus1.in_ready, 1'b0);
        check128("sub state_out hidden", bus1.state_out, ZEROS);
        while (!bus1.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = bus1.state_out;
    endtask

    task automatic run_par(input logic [127:0] s, input logic [127:0] exp);
        int lat2 = 0, lat4 = 0, lat16 = 0;
        logic [127:0] r2 = '0, r4 = '0, r16 = '0;
        p_valid = 1'b1;
        p_state = s;
        @(negedge clk);
        p_valid = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            if (bus2.out_valid && lat2 == 0)   begin lat2 = t;  r2 = bus2.state_out;   end
            if (bus4.out_valid && lat4 == 0)   begin lat4 = t;  r4 = bus4.state_out;   end
            if (bus16.out_valid && lat16 == 0) begin lat16 = t; r16 = bus16.state_out; end
            @(negedge clk);
        end
        checkint("par2 latency", lat2, 9);
        checkint("par4 latency", lat4, 5);
        checkint("par16 latency", lat16, 2);
        check128("par2 result", r2, exp);
        check128("par4 result", r4, exp);
        check128("par16 result", r16, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           nres;
        int           idx;
        int           last_cyc;
        logic         acc;
        logic [127:0] res;
        logic [127:0] rnd [8];

        bus1.in_valid  = 1'b0;
        bus1.state_in  = '0;
        bus1.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check1("rst in_ready", bus1.in_ready, 1'b0);
        check1("rst out_valid", bus1.out_valid, 1'b0);
        check1("rst busy", bus1.busy, 1'b0);
        check128("rst state_out", bus1.state_out, ZEROS);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check1("post-rst in_ready", bus1.in_ready, 1'b1);

        // T1: FIPS-197 round-1 vector, latency 17
        run1(T1_IN, lat, res);
        checkint("T1 latency", lat, 17);
        check128("T1 result", res, T1_OUT);
        @(negedge clk);
        check1("T1 back to idle", bus1.out_valid, 1'b0);

        // T2: sequential bytes, all-zero, all-ones
        run1(T2_IN, lat, res);
        check128("T2 seq result", res, T2_OUT);
        @(negedge clk);
        run1(ZEROS, lat, res);
        check128("T2 zeros result", res, ALL63);
        @(negedge clk);
        run1(ONES, lat, res);
        check128("T2 ones result", res, ALL16);
        @(negedge clk);

        // T3: downstream stall, ignored input pulses, handshake with in_valid high
        bus1.out_ready = 1'b0;
        run1(T1_IN, lat, res);
        checkint("T3 latency", lat, 17);
        for (int i = 0; i < 20; i++) begin
            bus1.in_valid = i[0];
            bus1.state_in = ONES ^ 128'(i);
            @(negedge clk);
            check1("T3 hold out_valid", bus1.out_valid, 1'b1);
            check128("T3 hold state_out", bus1.state_out, T1_OUT);
            check1("T3 hold in_ready", bus1.in_ready, 1'b0);
        end
        bus1.in_valid  = 1'b1;
        bus1.state_in  = T2_IN;
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        check1("T3 release out_valid", bus1.out_valid, 1'b0);
        check1("T3 release in_ready", bus1.in_ready, 1'b1);
        check1("T3 release not accepted", bus1.busy, 1'b0);
        check128("T3 release state_out", bus1.state_out, ZEROS);

        // T4: reset in SUB cycle 7, then a clean transaction
        bus1.in_valid = 1'b1;
        bus1.state_in = T1_IN;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check1("T4 busy before rst", bus1.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("T4 out_valid", bus1.out_valid, 1'b0);
        check1("T4 busy", bus1.busy, 1'b0);
        check1("T4 in_ready", bus1.in_ready, 1'b1);
        check128("T4 state_out", bus1.state_out, ZEROS);
        @(negedge clk);
        run1(ONES, lat, res);
        checkint("T4 latency", lat, 17);
        check128("T4 result", res, ALL16);
        @(negedge clk);

        // T5: back-to-back streaming of random states
        for (int k = 0; k < 8; k++) rnd[k] = {$urandom, $urandom, $urandom, $urandom};
        idx = 0;
        nres = 0;
        last_cyc = 0;
        acc = 1'b0;
        bus1.state_in = rnd[0];
        bus1.in_valid = 1'b1;
        for (int cyc = 0; cyc < 400 && nres < 8; cyc++) begin
            if (acc) begin
                idx++;
                if (idx >= 8) bus1.in_valid = 1'b0;
                else          bus1.state_in = rnd[idx];
            end
            if (bus1.out_valid) begin
                check128("T5 stream result", bus1.state_out, ref_sub(rnd[nres]));
                if (nres > 0) checkint("T5 stream interval", cyc - last_cyc, 18);
                last_cyc = cyc;
                nres++;
            end
            acc = bus1.in_valid && bus1.in_ready;
            @(negedge clk);
        end
        bus1.in_valid = 1'b0;
        checkint("T5 result count", nres, 8);
        @(negedge clk);

        // T6: wider PAR instances
        run_par(T1_IN, T1_OUT);
        run_par(T2_IN, T2_OUT);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
